// File: rtl/uart_8250_pkg.sv
// Shared definitions for the 8250-compatible UART receive path:
// FSM encoding, LCR field positions, trigger levels and timeout default.
package uart_8250_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRKWAIT
  } rx_state_e;

  localparam int LCR_WLS_LO = 0;
  localparam int LCR_WLS_HI = 1;
  localparam int LCR_STB    = 2;
  localparam int LCR_PEN    = 3;
  localparam int LCR_EPS    = 4;
  localparam int LCR_SP     = 5;

  localparam int TIMEOUT_TICKS_DEF = 640;
  localparam int SAMPLE_MID        = 7;

  // One received character plus the line status it carries into the LSR.
  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } rx_char_t;

  function automatic logic [4:0] trig_level(input logic [1:0] trig);
    case (trig)
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd14;
    endcase
  endfunction

endpackage

// File: rtl/uart_8250_rx_fifo.sv
// Synchronous show-ahead FIFO with push/pop/clear and occupancy count.
// Pointers carry one extra wrap bit; a full FIFO accepts push+pop together.
module uart_8250_rx_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     clr,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_8250_rx.sv
// 8250-compatible receiver: 16x oversampling deframer feeding a receive
// FIFO, with sticky line status, trigger-level and character-timeout causes.
module uart_8250_rx
  import uart_8250_pkg::*;
#(
  parameter int FIFO_DEPTH    = 32,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic                         RX_I,
  input  logic [15:0]                  DIVISOR_I,
  input  logic [5:0]                   LCR_I,
  input  logic [1:0]                   TRIG_I,
  input  logic                         POP_I,
  input  logic                         FIFO_CLR_I,
  input  logic                         ERR_CLR_I,
  output logic [7:0]                   DATA_O,
  output logic                         DR_O,
  output logic                         OE_O,
  output logic                         PE_O,
  output logic                         FE_O,
  output logic                         BI_O,
  output logic                         RDA_O,
  output logic                         TIMEOUT_O,
  output logic [$clog2(FIFO_DEPTH):0]  COUNT_O
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  // Only the first stop bit is ever checked.
  logic lcr_stb_unused;
  assign lcr_stb_unused = LCR_I[LCR_STB];

  // Line synchronizer, idle-high reset value.
  logic [1:0] rx_pipe;
  logic       rx_sync;
  assign rx_sync = rx_pipe[1];

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) rx_pipe <= 2'b11;
    else        rx_pipe <= {rx_pipe[0], RX_I};
  end

  // Oversample tick; the reload value is latched at wrap so a divisor
  // change never truncates or stretches the current tick period.
  logic [15:0] div_cnt, div_last;
  logic        tick;
  assign tick = (div_cnt == div_last);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      div_cnt  <= '0;
      div_last <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      div_last <= (DIVISOR_I == 16'd0) ? 16'd0 : DIVISOR_I - 16'd1;
    end else begin
      div_cnt  <= div_cnt + 16'd1;
    end
  end

  rx_state_e  state, state_nx;
  logic [3:0] s_cnt;
  logic [2:0] b_cnt;
  logic [7:0] shreg;
  logic [1:0] wls_q;
  logic       pen_q, eps_q, sp_q;
  logic       par_bit, par_err;
  logic       mid, last_bit, par_exp, brk_det;
  logic       clr_scnt, lcr_load, shift_en, par_en, stop_en;

  assign mid      = tick && (s_cnt == 4'(SAMPLE_MID));
  assign last_bit = (b_cnt == {1'b1, wls_q});
  assign par_exp  = sp_q ? ~eps_q : (eps_q ? ^shreg : ~^shreg);
  assign brk_det  = !rx_sync && (shreg == 8'd0) && !par_bit;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (!rx_sync) state_nx = ST_START;
      ST_START:   if (mid) state_nx = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:    if (mid && last_bit) state_nx = pen_q ? ST_PARITY : ST_STOP;
      ST_PARITY:  if (mid) state_nx = ST_STOP;
      ST_STOP:    if (mid) state_nx = rx_sync ? ST_IDLE : ST_BRKWAIT;
      ST_BRKWAIT: if (rx_sync) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_scnt = 1'b0;
    lcr_load = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    unique case (state)
      ST_IDLE:   clr_scnt = !rx_sync;
      ST_START:  lcr_load = mid && !rx_sync;
      ST_DATA:   shift_en = mid;
      ST_PARITY: par_en   = mid;
      ST_STOP:   stop_en  = mid;
      default:   ;
    endcase
  end

  // Frame datapath: LCR is frozen at the end of a valid start bit.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      s_cnt   <= '0;
      b_cnt   <= '0;
      shreg   <= '0;
      wls_q   <= '0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
      par_bit <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (clr_scnt)  s_cnt <= '0;
      else if (tick) s_cnt <= s_cnt + 4'd1;
      if (lcr_load) begin
        wls_q   <= LCR_I[LCR_WLS_HI:LCR_WLS_LO];
        pen_q   <= LCR_I[LCR_PEN];
        eps_q   <= LCR_I[LCR_EPS];
        sp_q    <= LCR_I[LCR_SP];
        shreg   <= '0;
        b_cnt   <= '0;
        par_bit <= 1'b0;
        par_err <= 1'b0;
      end
      if (shift_en) begin
        shreg[b_cnt] <= rx_sync;
        b_cnt        <= b_cnt + 3'd1;
      end
      if (par_en) begin
        par_bit <= rx_sync;
        par_err <= (rx_sync != par_exp);
      end
    end
  end

  // Character is pushed the clock after the mid-stop sample.
  rx_char_t push_req;
  logic     push_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      push_q   <= 1'b0;
      push_req <= '0;
    end else begin
      push_q <= stop_en;
      if (stop_en) begin
        push_req.data <= brk_det ? 8'd0 : shreg;
        push_req.pe   <= par_err;
        push_req.fe   <= !rx_sync;
        push_req.bi   <= brk_det;
      end
    end
  end

  logic          fifo_full, fifo_empty, overrun;
  logic [CW-1:0] fifo_count;

  uart_8250_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (push_q),
    .din   (push_req.data),
    .pop   (POP_I),
    .clr   (FIFO_CLR_I),
    .dout  (DATA_O),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign overrun = push_q && fifo_full && !POP_I && !FIFO_CLR_I;

  // Sticky status: a new event in the clear cycle survives the clear.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      OE_O <= 1'b0;
      PE_O <= 1'b0;
      FE_O <= 1'b0;
      BI_O <= 1'b0;
    end else begin
      OE_O <= (OE_O && !ERR_CLR_I) || overrun;
      PE_O <= (PE_O && !ERR_CLR_I) || (push_q && push_req.pe);
      FE_O <= (FE_O && !ERR_CLR_I) || (push_q && push_req.fe);
      BI_O <= (BI_O && !ERR_CLR_I) || (push_q && push_req.bi);
    end
  end

  logic [TW-1:0] to_cnt;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I)
      to_cnt <= '0;
    else if (push_q || POP_I || FIFO_CLR_I || fifo_empty)
      to_cnt <= '0;
    else if (tick && (to_cnt != TW'(TIMEOUT_TICKS)))
      to_cnt <= to_cnt + 1'b1;
  end

  assign TIMEOUT_O = (to_cnt == TW'(TIMEOUT_TICKS)) && !fifo_empty;
  assign COUNT_O   = fifo_count;
  assign DR_O      = !fifo_empty;
  assign RDA_O     = (fifo_count >= CW'(trig_level(TRIG_I)));

endmodule

// File: tb/tb_uart_8250_rx.sv
// Directed bench for uart_8250_rx: serial frames in, queue-based model of
// the receive FIFO and line status, checked every settled cycle.
module tb_uart_8250_rx;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b0;
  logic          RX_I  = 1'b1;
  logic [15:0]   DIVISOR_I = 16'd1;
  logic [5:0]    LCR_I = 6'b000011;
  logic [1:0]    TRIG_I = 2'b00;
  logic          POP_I = 1'b0, FIFO_CLR_I = 1'b0, ERR_CLR_I = 1'b0;
  logic [7:0]    DATA_O;
  logic          DR_O, OE_O, PE_O, FE_O, BI_O, RDA_O, TIMEOUT_O;
  logic [CW-1:0] COUNT_O;

  always #5 CLK_I = ~CLK_I;

  uart_8250_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_TICKS(640)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .RX_I(RX_I), .DIVISOR_I(DIVISOR_I),
    .LCR_I(LCR_I), .TRIG_I(TRIG_I), .POP_I(POP_I), .FIFO_CLR_I(FIFO_CLR_I),
    .ERR_CLR_I(ERR_CLR_I), .DATA_O(DATA_O), .DR_O(DR_O), .OE_O(OE_O),
    .PE_O(PE_O), .FE_O(FE_O), .BI_O(BI_O), .RDA_O(RDA_O),
    .TIMEOUT_O(TIMEOUT_O), .COUNT_O(COUNT_O)
  );

  int vectors = 0, miscompares = 0;
  byte unsigned q[$];
  bit m_oe = 0, m_pe = 0, m_fe = 0, m_bi = 0;
  bit chk_en = 0;
  int idle_clk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int eff_div();
    return (DIVISOR_I == 16'd0) ? 1 : int'(DIVISOR_I);
  endfunction

  function automatic int trig_lvl(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 14;
    endcase
  endfunction

  // Even parity: data+parity carry an even number of ones; stick forces ~EPS.
  function automatic bit want_parity(input byte unsigned d);
    bit odd_ones;
    odd_ones = ($countones(d) % 2) == 1;
    if (LCR_I[5]) return ~LCR_I[4];
    return LCR_I[4] ? odd_ones : !odd_ones;
  endfunction

  task automatic model_rx(input byte unsigned d, input bit pen, input bit pbit, input bit stopb);
    bit bi;
    bi = (d == 0) && (!pen || !pbit) && !stopb;
    if (q.size() == DEPTH) m_oe = 1;
    else q.push_back(bi ? 8'd0 : d);
    if (pen && (pbit != want_parity(d))) m_pe = 1;
    if (!stopb) m_fe = 1;
    if (bi) m_bi = 1;
  endtask

  // Settled-cycle comparison against the model.
  always @(negedge CLK_I) begin
    if (chk_en) begin
      idle_clk++;
      check("data",  DATA_O,  (q.size() != 0) ? 32'(q[0]) : 32'd0);
      check("dr",    DR_O,    32'(q.size() != 0));
      check("count", COUNT_O, 32'(q.size()));
      check("oe",    OE_O,    32'(m_oe));
      check("pe",    PE_O,    32'(m_pe));
      check("fe",    FE_O,    32'(m_fe));
      check("bi",    BI_O,    32'(m_bi));
      check("rda",   RDA_O,   32'(q.size() >= trig_lvl(TRIG_I)));
      if (q.size() == 0 || idle_clk < 600 * eff_div())
        check("timeout", TIMEOUT_O, 32'd0);
      else if (idle_clk > 680 * eff_div())
        check("timeout", TIMEOUT_O, 32'd1);
    end else begin
      idle_clk = 0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  task automatic send_bit(input bit v);
    RX_I = v;
    wait_clk(16 * eff_div());
  endtask

  task automatic send_frame(input byte unsigned d, input int nbits, input bit pen,
                            input bit pbit, input bit stopb);
    byte unsigned m;
    chk_en = 0;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stopb);
    RX_I = 1'b1;
    m = byte'((1 << nbits) - 1);
    model_rx(d & m, pen, pbit, stopb);
    wait_clk(2);
    chk_en = 1;
  endtask

  task automatic send8(input byte unsigned d);
    send_frame(d, 8, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_pop();
    chk_en = 0;
    POP_I = 1'b1;
    wait_clk(1);
    POP_I = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    wait_clk(1);
    chk_en = 1;
  endtask

  task automatic do_clr();
    chk_en = 0;
    FIFO_CLR_I = 1'b1;
    wait_clk(1);
    FIFO_CLR_I = 1'b0;
    q.delete();
    wait_clk(1);
    chk_en = 1;
  endtask

  task automatic do_errclr();
    chk_en = 0;
    ERR_CLR_I = 1'b1;
    wait_clk(1);
    ERR_CLR_I = 1'b0;
    m_oe = 0; m_pe = 0; m_fe = 0; m_bi = 0;
    wait_clk(1);
    chk_en = 1;
  endtask

  task automatic model_reset();
    q.delete();
    m_oe = 0; m_pe = 0; m_fe = 0; m_bi = 0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_data", DATA_O, 32'd0);
    check("rst_dr", DR_O, 32'd0);
    check("rst_count", COUNT_O, 32'd0);
    check("rst_flags", {OE_O, PE_O, FE_O, BI_O}, 32'd0);
    check("rst_rda", RDA_O, 32'd0);
    check("rst_timeout", TIMEOUT_O, 32'd0);
    wait_clk(3);
    RST_I = 1'b1;
    wait_clk(3);
    chk_en = 1;
    wait_clk(4);

    // 8N1 at divisor 1
    send8(8'h55);
    check("8n1_data", DATA_O, 32'h55);
    check("8n1_dr", DR_O, 32'd1);
    check("8n1_flags", {PE_O, FE_O, BI_O}, 32'd0);

    // Divisor 3 and divisor 0 (treated as 1)
    DIVISOR_I = 16'd3;
    wait_clk(8);
    send8(8'hC3);
    DIVISOR_I = 16'd0;
    wait_clk(8);
    send8(8'h0F);
    DIVISOR_I = 16'd1;
    wait_clk(8);
    check("div_count", COUNT_O, 32'd3);
    do_pop(); do_pop(); do_pop();
    check("pop_empty", COUNT_O, 32'd0);

    // 7E1 with a wrong parity bit, then LSR read
    LCR_I = 6'b011010;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    check("7e1_data", DATA_O, 32'h41);
    check("7e1_pe", PE_O, 32'd1);
    do_errclr();
    check("errclr_pe", PE_O, 32'd0);
    do_clr();

    // 5-bit stick parity (mark), correct parity
    LCR_I = 6'b101000;
    send_frame(8'hFF, 5, 1'b1, 1'b1, 1'b1);
    check("5s_data", DATA_O, 32'h1F);
    check("5s_pe", PE_O, 32'd0);
    do_clr();

    // Framing error
    LCR_I = 6'b000011;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0);
    check("fe_flag", {FE_O, BI_O}, 32'b10);
    check("fe_data", DATA_O, 32'hA5);
    do_errclr();
    do_clr();

    // Break: line low two frame times
    chk_en = 0;
    RX_I = 1'b0;
    wait_clk(320);
    RX_I = 1'b1;
    model_rx(8'h00, 1'b0, 1'b0, 1'b0);
    wait_clk(6);
    chk_en = 1;
    wait_clk(2);
    check("brk_count", COUNT_O, 32'd1);
    check("brk_data", DATA_O, 32'h00);
    check("brk_bi_fe", {BI_O, FE_O}, 32'b11);
    do_errclr();
    do_clr();

    // Overrun: one more character than the FIFO holds
    for (int i = 0; i < DEPTH + 1; i++) send8(byte'(i + 1));
    check("ovr_count", COUNT_O, 32'd32);
    check("ovr_oe", OE_O, 32'd1);
    check("ovr_head", DATA_O, 32'h01);
    do_errclr();
    do_clr();

    // Trigger level and character timeout
    TRIG_I = 2'b01;
    send8(8'h11); send8(8'h22); send8(8'h33);
    check("rda_3", RDA_O, 32'd0);
    send8(8'h44);
    check("rda_4", RDA_O, 32'd1);
    do_pop(); do_pop(); do_pop();
    wait_clk(700);
    check("to_rise", TIMEOUT_O, 32'd1);
    check("to_head", DATA_O, 32'h44);
    do_pop();
    check("to_fall", TIMEOUT_O, 32'd0);
    TRIG_I = 2'b00;

    // Short low glitch is not a start bit
    send8(8'h99);
    RX_I = 1'b0;
    wait_clk(3);
    RX_I = 1'b1;
    wait_clk(40);
    check("glitch_count", COUNT_O, 32'd1);

    // Asynchronous reset in the middle of the data bits
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
    chk_en = 0;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    wait_clk(8);
    RST_I = 1'b0;
    #1;
    check("arst_count", COUNT_O, 32'd0);
    check("arst_data", DATA_O, 32'd0);
    check("arst_flags", {DR_O, OE_O, PE_O, FE_O, BI_O}, 32'd0);
    RX_I = 1'b1;
    model_reset();
    wait_clk(3);
    RST_I = 1'b1;
    wait_clk(3);
    chk_en = 1;
    send8(8'h3C);
    check("post_rst_data", DATA_O, 32'h3C);
    check("post_rst_count", COUNT_O, 32'd1);

    chk_en = 0;
    wait_clk(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_8250_rx.md
# uart_8250_rx

Receive half of the 8250-compatible UART: oversamples the serial RX line, deframes 5–8 bit characters with optional parity, and queues them in a receive FIFO with per-line status. Sits beside the transmitter under the Wishbone register file, which owns RBR/LSR/IIR decoding. It drives this block's pop/clear strobes and consumes its data, status and interrupt-cause outputs.

## Interface
- FIFO_DEPTH, 32, receive FIFO entries; power of two, ≥ 16.
- TIMEOUT_TICKS, 640, oversample ticks of FIFO inactivity (4 frames × 10 bits × 16) before a timeout.
- CLK_I  in  1  system clock.
- RST_I  in  1  reset, asynchronous, active-low.
- RX_I  in  1  serial input, idle high, asynchronous to CLK_I.
- DIVISOR_I  in  16  baud divisor; one oversample tick every DIVISOR_I clocks; 0 treated as 1.
- LCR_I  in  6  [1:0] word length 5/6/7/8, [2] stop bits (ignored; only the first stop bit is checked), [3] parity enable, [4] even parity, [5] stick parity.
- TRIG_I  in  2  FIFO trigger level: 00→1, 01→4, 10→8, 11→14.
- POP_I  in  1  one-cycle strobe: RBR read; pops the head entry.
- FIFO_CLR_I  in  1  one-cycle strobe: FCR[1]; empties the FIFO.
- ERR_CLR_I  in  1  one-cycle strobe: LSR read; clears OE/PE/FE/BI.
- DATA_O  out  8  head entry, show-ahead, zero-extended above word length; 0 when empty.
- DR_O  out  1  FIFO non-empty (LSR[0]).
- OE_O, PE_O, FE_O, BI_O  out  1 each  sticky overrun/parity/framing/break (LSR[1..4]).
- RDA_O  out  1  count ≥ trigger level.
- TIMEOUT_O  out  1  character-timeout cause.
- COUNT_O  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- 2-flop synchronizer on RX_I, reset value 1; the FSM sees only the synchronized value.
- Tick generator: a 16-bit counter wraps at max(DIVISOR_I,1)−1 and emits a 1-cycle tick. A divisor change takes effect at the next wrap.
- FSM states IDLE, START, DATA, PARITY, STOP, BRKWAIT. A 4-bit sample counter advances on ticks and samples the line at count 7 (mid-bit).
  - IDLE: synced line low → START, sample counter cleared.
  - START: mid-bit high → IDLE (glitch, nothing pushed); low → DATA.
  - DATA: shift the line LSB-first every 16 ticks for 5+LCR_I[1:0] bits, then → PARITY if LCR_I[3], else → STOP.
  - PARITY: expected bit = stick ? ~LCR_I[4] : (even ? ^data : ~^data); a mismatch flags a parity error.
  - STOP: at mid-bit, push the character. Line low → FE. If data, parity and stop are all zero → BI and push 0x00. Then go to IDLE if the line is high, else BRKWAIT.
  - BRKWAIT: stay until the synced line is high, then → IDLE.
- LCR_I is sampled at the START→DATA transition and held for the frame.
- Push when full: character discarded, OE set, FIFO unchanged. A push and a pop in the same cycle on a full FIFO are both accepted.
- Error flags are set in the push cycle and cleared by ERR_CLR_I. A set event in the same cycle as ERR_CLR_I wins.
- FIFO_CLR_I has priority over push and pop in the same cycle. It does not disturb the FSM or the error flags.
- POP_I when empty is ignored.
- Timeout counter advances on ticks while the FIFO is non-empty. It resets on push, pop or clear.
  - TIMEOUT_O rises when the counter reaches TIMEOUT_TICKS.
  - TIMEOUT_O falls on the next push, pop or clear, or when the FIFO is empty.

## Timing
- Reset values: DATA_O 0, DR_O 0, OE/PE/FE/BI 0, RDA_O 0, TIMEOUT_O 0, COUNT_O 0, FSM IDLE, pointers 0.
- RX_I edge to FSM visibility: 2 clocks. Start detected to mid-start sample: 8 ticks.
- Character push: the clock after the mid-stop tick. DR_O, COUNT_O and DATA_O update the following clock.
- POP_I: DATA_O, COUNT_O and DR_O show the next entry one clock later.
- Pointers carry $clog2(FIFO_DEPTH)+1 bits. Full when the addresses match and the MSBs differ; wrap-around is natural.
- Asynchronous reset mid-frame: partial character dropped, FIFO emptied, FSM back to IDLE.

## Structure
- Shared package uart_8250_pkg: FSM state encoding, LCR field bit positions, trigger-level lookup constants, TIMEOUT_TICKS default.
- Sub-module uart_8250_rx_fifo: synchronous show-ahead FIFO with push/pop/clear/count. Reused later by the transmitter rework.

## Test plan
- DIVISOR_I=1, 8N1, send 0x55 (16 clocks per bit) → DR_O=1 and DATA_O=0x55 after the stop bit; PE/FE/BI stay 0.
- 7E1, send 0x41 with a wrong parity bit → DATA_O=0x41, PE_O=1; ERR_CLR_I pulse → PE_O=0.
- Hold RX_I low for 2 frame times, then release → one 0x00 entry, BI_O=1, FE_O=1, exactly one push.
- Send 33 characters with no pops (FIFO_DEPTH=32) → COUNT_O=32, OE_O=1, head still holds the first character.
- TRIG_I=01, send 3 bytes → RDA_O=0; 4th byte → RDA_O=1; leave idle 640 ticks with 1 byte queued → TIMEOUT_O=1; POP_I → TIMEOUT_O=0.
- 3-clock low glitch on RX_I → no push; RST_I asserted at mid-DATA → outputs at reset values, next frame received correctly.
